// File: rtl/mult_product_round_if.sv
// rtl/mult_product_round_if.sv - product/sign input stream and rounded result output stream
interface mult_product_round_if;
    logic        in_valid;
    logic        in_ready;
    logic [61:0] prod;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        zero;

    modport master (
        output in_valid, prod, sign_in, out_ready,
        input  in_ready, out_valid, result, ovf, zero
    );

    modport slave (
        input  in_valid, prod, sign_in, out_ready,
        output in_ready, out_valid, result, ovf, zero
    );
endinterface

// File: rtl/mult_product_round.sv
// rtl/mult_product_round.sv - two-stage rescale/round/saturate of the multiplier product
// MULT_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the product is truncated.
module mult_product_round #(
    parameter int FRAC_BITS = 26
) (
    input  logic clk,
    input  logic rst_n,
    mult_product_round_if.slave bus
);

    logic        s1_valid;
    logic [30:0] s1_mag;
    logic        s1_hi_ovf;
    logic        s1_sign;
    logic        s2_valid;
    logic [31:0] result_q;
    logic        ovf_q;
    logic        zero_q;

    logic        s1_en;
    logic        s2_en;
    logic [61:0] shifted;
    logic        hi_ovf_c;
    logic        ovf_c;
    logic [30:0] rounded;
    logic [30:0] mag_c;

    assign s2_en        = ~s2_valid | bus.out_ready;
    assign s1_en        = ~s1_valid | s2_en;
    assign bus.in_ready = s1_en;

    // Zero-extended shift keeps the overflow reduction legal for every FRAC_BITS.
    assign shifted  = bus.prod >> FRAC_BITS;
    assign hi_ovf_c = |shifted[61:31];

`ifdef MULT_ROUND_NEAREST_EN
    logic        s1_inc;
    logic        inc_c;
    logic [31:0] sum;

    assign inc_c   = bus.prod[FRAC_BITS-1] & ((|bus.prod[FRAC_BITS-2:0]) | bus.prod[FRAC_BITS]);
    assign sum     = {1'b0, s1_mag} + {31'd0, s1_inc};
    assign ovf_c   = s1_hi_ovf | sum[31];
    assign rounded = sum[30:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inc <= 1'b0;
        end else if (s1_en) begin
            s1_inc <= inc_c;
        end
    end
`else
    assign ovf_c   = s1_hi_ovf;
    assign rounded = s1_mag;
`endif

    assign mag_c = ovf_c ? 31'h7FFF_FFFF : rounded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mag    <= '0;
            s1_hi_ovf <= 1'b0;
            s1_sign   <= 1'b0;
        end else if (s1_en) begin
            s1_valid  <= bus.in_valid;
            s1_mag    <= shifted[30:0];
            s1_hi_ovf <= hi_ovf_c;
            s1_sign   <= bus.sign_in;
        end
    end

    // A zero magnitude always carries a positive sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            result_q <= {(mag_c != 31'd0) & s1_sign, mag_c};
            ovf_q    <= ovf_c;
            zero_q   <= (mag_c == 31'd0);
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_mult_product_round.sv
// tb/tb_mult_product_round.sv - scoreboard bench for mult_product_round
module tb_mult_product_round;

    localparam int FRAC_BITS = 26;
`ifdef MULT_ROUND_NEAREST_EN
    localparam bit NEAREST = 1'b1;
`else
    localparam bit NEAREST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_product_round_if bus();

    mult_product_round #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int popped = 0;
    logic [33:0] exp_q[$];
    bit stalled = 1'b0;
    bit saw_in_ready_low = 1'b0;
    logic [33:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [61:0] p, input logic s, input logic [31:0] r,
                        input logic o, input logic z);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.prod     = p;
        bus.sign_in  = s;
        #2;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (bus.in_ready) begin
            exp_q.push_back({r, o, z});
            pushed++;
        end else begin
            check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (popped != pushed && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", popped, pushed);
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold and in_ready.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            check("in_ready", {63'd0, bus.in_ready},
                  {63'd0, !((pushed - popped) == 2 && !bus.out_ready)});
            if (!bus.in_ready) saw_in_ready_low = 1'b1;
            if (stalled) begin
                check("out_valid_held", {63'd0, bus.out_valid}, 64'd1);
                check("result_held", {30'd0, bus.result, bus.ovf, bus.zero}, {30'd0, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.result);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    check("result", {30'd0, bus.result, bus.ovf, bus.zero}, {30'd0, e});
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = {bus.result, bus.ovf, bus.zero};
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #3;
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_result", {32'd0, bus.result}, 64'd0);
        check("reset_ovf", {63'd0, bus.ovf}, 64'd0);
        check("reset_zero", {63'd0, bus.zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        check("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

        // Unity with two-cycle latency
        send(62'd1 << 52, 1'b1, 32'h8400_0000, 1'b0, 1'b0);
        idle();
        #3;
        check("latency_cycle1", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        #3;
        check("latency_cycle2", {63'd0, bus.out_valid}, 64'd1);
        drain();

        // Rounding ties, saturation, zero sign, back-to-back
        send((62'd5 << 26) | (62'd1 << 25), 1'b0, NEAREST ? 32'd6 : 32'd5, 1'b0, 1'b0);
        send((62'd4 << 26) | (62'd1 << 25), 1'b0, 32'd4, 1'b0, 1'b0);
        send((62'd4 << 26) | (62'd1 << 25) | 62'd1, 1'b0, NEAREST ? 32'd5 : 32'd4, 1'b0, 1'b0);
        send((62'd3 << 26) | (62'd3 << 24), 1'b1,
             NEAREST ? 32'h8000_0004 : 32'h8000_0003, 1'b0, 1'b0);
        send(62'd1 << 57, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send((62'h7FFF_FFFF << 26) | (62'd3 << 24), 1'b0, 32'h7FFF_FFFF, NEAREST, 1'b0);
        send((62'd1 << 25) - 62'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        idle();
        drain();

        // Back-pressure: OUT_READY low for four cycles while streaming
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(62'(10 + i) << 26, 1'(i & 1),
                         {1'(i & 1), 31'(10 + i)}, 1'b0, 1'b0);
                end
                idle();
            end
            begin
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_fell", {63'd0, saw_in_ready_low}, 64'd1);

        // Reset with both stages full discards everything
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(62'd7 << 26, 1'b0, 32'd7, 1'b0, 1'b0);
        send(62'd8 << 26, 1'b0, 32'd8, 1'b0, 1'b0);
        idle();
        #3;
        check("full_before_reset", {63'd0, bus.out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("async_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        exp_q.delete();
        pushed = 0;
        popped = 0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            check("no_stale_output", {63'd0, bus.out_valid}, 64'd0);
        end
        check("ready_after_midreset", {63'd0, bus.in_ready}, 64'd1);
        check("scoreboard_empty", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_product_round.md
Name: mult_product_round

Overview:
- Post-multiplier stage of the natural-logarithm datapath; consumes the 62-bit magnitude product Y of MULTIPLIER_32BITS plus the product sign.
- Rescales to the datapath fixed-point format (FRAC_BITS fractional bits), rounds and saturates to a 31-bit magnitude, and re-attaches the sign into a 32-bit sign-magnitude word.
- Two-stage valid/ready pipeline, so the multiplier result path is registered and can absorb back-pressure from the next logarithm stage.

Parameters:
- FRAC_BITS, 26, fractional bits of operands and result; legal range 2..31.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  product/sign pair valid.
- IN_READY  output  1  stage accepts the pair this cycle.
- PROD  input  62  unsigned magnitude product (scale 2^(2*FRAC_BITS)).
- SIGN_IN  input  1  product sign (1 = negative).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- RESULT  output  32  {sign, 31-bit magnitude}, scale 2^FRAC_BITS.
- OVF  output  1  result saturated; qualified by OUT_VALID.
- ZERO  output  1  result magnitude is 0; qualified by OUT_VALID.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): both stage valids 0, OUT_VALID=0, RESULT=0, OVF=0, ZERO=0. IN_READY=1 from the first cycle after reset. Reset mid-transfer discards all in-flight data.
- Transfer rules:
  - In: IN_VALID & IN_READY. Out: OUT_VALID & OUT_READY.
  - IN_READY = ~s1_valid | ~s2_valid | OUT_READY. Combinational from OUT_READY; no combinational path from IN_VALID to IN_READY.
- Stage 1 captures on an accepted input:
  - shifted = PROD[61:FRAC_BITS]
  - lsb = PROD[FRAC_BITS], guard = PROD[FRAC_BITS-1], sticky = |PROD[FRAC_BITS-2:0] (0 when FRAC_BITS=2 has no bits below guard... i.e. sticky = PROD[0] at FRAC_BITS=2)
  - hi_ovf = |shifted[61-FRAC_BITS:31]
  - inc = guard & (sticky | lsb)
  - Registers: shifted[30:0], inc, hi_ovf, SIGN_IN.
- Stage 2: sum = {1'b0, shifted[30:0]} + inc (32 bits).
  - ovf = hi_ovf | sum[31].
  - mag = ovf ? 31'h7FFF_FFFF : sum[30:0].
  - sign = (mag == 0) ? 0 : s1_sign. Negative zero is never produced.
  - RESULT = {sign, mag}, OVF = ovf, ZERO = (mag == 0).
- Stage registers advance when downstream space exists. Stage 2 loads when ~s2_valid | OUT_READY. Stage 1 loads when IN_READY. Valid bits follow the same enables.
- Latency: 2 cycles from input accept to OUT_VALID with no stall. Throughput 1 result/cycle.
- Back-pressure:
  - While OUT_VALID & ~OUT_READY, RESULT/OVF/ZERO hold stable.
  - Stage 1 still fills if empty, so at most 2 items are held.
  - IN_READY falls only when both stages are full and OUT_READY=0.
  - Order is preserved; no item is dropped or duplicated.
- Simultaneous accept at input and output with both stages full: shifts through with no bubble.

Optional Feature:
- Macro: MULT_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even as above (inc logic active).
- Undefined: truncation. inc forced 0, guard/sticky logic omitted, ovf = hi_ovf only.
- Pipeline depth, handshake and saturation are identical in both builds.

Test Plan:
- Unity: PROD=1<<52, SIGN_IN=1, OUT_READY=1 -> 2 cycles later RESULT=32'h8400_0000, OVF=0, ZERO=0.
- Rounding ties, feature defined (same stimuli undefined: 5, 4, 4):
  - PROD=(5<<26)|(1<<25) -> magnitude 6.
  - PROD=(4<<26)|(1<<25) -> magnitude 4.
  - PROD=(4<<26)|(1<<25)|1 -> magnitude 5.
- Saturation:
  - PROD=1<<57 -> RESULT=32'h7FFF_FFFF, OVF=1.
  - PROD=(32'h7FFF_FFFF<<26)|(3<<24) -> RESULT=32'h7FFF_FFFF with OVF=1 (defined) or OVF=0 (undefined).
- Zero sign: PROD=(1<<25)-1, SIGN_IN=1 -> RESULT=32'h0000_0000, ZERO=1.
- Back-pressure: stream 5 distinct products with IN_VALID held high, OUT_READY=0 for cycles 2..5 -> IN_READY=0 while both stages full; all 5 results emerge in order, RESULT stable while stalled.
- Reset: assert RST_N=0 with both stages full -> OUT_VALID=0 immediately (asynchronous). After release, IN_READY=1 and no stale result appears.
